// File: rtl/out_sched_pkg.sv
// Shared types and defaults for the clk3 output frame scheduler.
package out_sched_pkg;

  typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_FRAME_LEN = 128;
  localparam int DEF_CNT_W     = 8;

  function automatic int clog2(input int value);
    int r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sched_skid_fifo.sv
// Small synchronous skid FIFO; the head entry is visible combinationally on rd_data.
module sched_skid_fifo
  import out_sched_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = 8,
  localparam int PTR_W  = clog2(DEPTH)
) (
  input  logic              clk3,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [PTR_W:0]    cnt
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  always_ff @(posedge clk3) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // The caller never writes when full nor reads when empty, so cnt needs no guarding.
  always_ff @(posedge clk3) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      if (wr_en && !rd_en) cnt <= cnt + (PTR_W+1)'(1);
      else if (!wr_en && rd_en) cnt <= cnt - (PTR_W+1)'(1);
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/out_frame_sched.sv
// clk3 output scheduler: drains the async FIFO into a skid buffer and emits FRAME_LEN results per frame.
// Defining OUT_SCHED_UNDERRUN_CNT_EN adds a saturating underrun_cnt output.
module out_frame_sched
  import out_sched_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FRAME_LEN  = DEF_FRAME_LEN,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int SKID_DEPTH = 8,
  parameter int PREFILL    = 4
) (
  input  logic              clk3,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              in_busy,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rdata,
  output logic              fifo_rinc,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              frame_done,
  output logic              busy
`ifdef OUT_SCHED_UNDERRUN_CNT_EN
  ,
  output logic [15:0]       underrun_cnt
`endif
);

  localparam int               SKID_PW = clog2(SKID_DEPTH);
  localparam logic [CNT_W-1:0] LEN     = CNT_W'(FRAME_LEN);

  state_t            state;
  logic [CNT_W-1:0]  rd_cnt;
  logic [CNT_W-1:0]  out_cnt;
  logic              inflight;
  logic              active;
  logic              pop;
  logic [SKID_PW:0]  skid_cnt;
  logic [DATA_W-1:0] skid_head;

  assign active = (state == FILL) || (state == STREAM);

  // Counting the in-flight read keeps room for data that lands next cycle; rd_cnt stops us reading the next frame.
  assign fifo_rinc = active && !fifo_empty && (rd_cnt < LEN) &&
                     ((int'(skid_cnt) + int'(inflight)) < SKID_DEPTH);

  assign pop = (state == STREAM) && (skid_cnt != '0) && !in_busy && (out_cnt < LEN);

  sched_skid_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk3   (clk3),
    .rst    (rst),
    .wr_en  (inflight),
    .wr_data(fifo_rdata),
    .rd_en  (pop),
    .rd_data(skid_head),
    .cnt    (skid_cnt)
  );

  always_ff @(posedge clk3) begin
    if (rst) begin
      state      <= IDLE;
      rd_cnt     <= '0;
      out_cnt    <= '0;
      inflight   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      inflight   <= fifo_rinc;
      out_valid  <= pop;
      out_data   <= pop ? skid_head : '0;
      frame_done <= 1'b0;
      if (fifo_rinc) rd_cnt <= rd_cnt + CNT_W'(1);
      if (pop)       out_cnt <= out_cnt + CNT_W'(1);
      case (state)
        IDLE: begin
          if (frame_start) begin
            state   <= FILL;
            rd_cnt  <= '0;
            out_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        FILL: begin
          if ((int'(skid_cnt) >= PREFILL) || (rd_cnt == LEN)) state <= STREAM;
        end
        STREAM: begin
          if (out_cnt == LEN) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef OUT_SCHED_UNDERRUN_CNT_EN
  // Only starvation counts; a pop held off by in_busy is back-pressure, not an underrun.
  always_ff @(posedge clk3) begin
    if (rst) begin
      underrun_cnt <= '0;
    end else if ((state == IDLE) && frame_start) begin
      underrun_cnt <= '0;
    end else if ((state == STREAM) && (out_cnt < LEN) && (skid_cnt == '0) && !in_busy &&
                 (underrun_cnt != 16'hFFFF)) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_out_frame_sched.sv
// Scoreboard bench for out_frame_sched: the bench plays the async FIFO and checks output order and timing.
module tb_out_frame_sched;

  localparam int FRAME_LEN  = 128;
  localparam int SKID_DEPTH = 8;
  localparam int PREFILL    = 4;
  localparam int N_RAND     = 150;

  logic        clk3 = 1'b0;
  logic        rst;
  logic        frame_start;
  logic        in_busy;
  logic        fifo_empty;
  logic [15:0] fifo_rdata;
  logic        fifo_rinc;
  logic        out_valid;
  logic [15:0] out_data;
  logic        frame_done;
  logic        busy;
`ifdef OUT_SCHED_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  always #5 clk3 = ~clk3;

  out_frame_sched dut (
    .clk3       (clk3),
    .rst        (rst),
    .frame_start(frame_start),
    .in_busy    (in_busy),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_rinc  (fifo_rinc),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .frame_done (frame_done),
    .busy       (busy)
`ifdef OUT_SCHED_UNDERRUN_CNT_EN
    ,
    .underrun_cnt(underrun_cnt)
`endif
  );

  // Inputs and read strobe as seen by the DUT at each rising edge.
  logic rst_e  = 1'b0;
  logic busy_e = 1'b0;
  logic fs_e   = 1'b0;
  logic rinc_e = 1'b0;
  always @(posedge clk3) begin
    rst_e  <= rst;
    busy_e <= in_busy;
    fs_e   <= frame_start;
    rinc_e <= fifo_rinc;
  end

  logic [15:0] fifo_q[$];
  logic [15:0] exp_q[$];
  bit chk_lat   = 0;
  bit chk_under = 0;
  bit end_check = 0;

  // ---------------- monitor / scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  bit in_frame = 0;
  bit first_seen = 0;
  bit done_due = 0;
  int lat = 0, vcnt = 0, rcnt = 0, first_cyc = 0, last_cyc = 0;
  logic [15:0] exp_v;

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk3) begin
    if (rst_e) begin
      check(!out_valid && out_data == 16'd0 && !busy && !frame_done && !fifo_rinc, "reset_state",
            {out_valid, busy, frame_done, fifo_rinc}, 0);
      in_frame = 0; vcnt = 0; rcnt = 0; done_due = 0;
    end else begin
      lat++;
      if (fs_e && !in_frame) begin
        in_frame = 1; lat = 0; vcnt = 0; rcnt = 0; first_seen = 0;
      end
      check(in_frame || !rinc_e, "rinc_outside_frame", rinc_e, 0);
      if (rinc_e) rcnt++;
      check(out_valid || out_data == 16'd0, "data_zero_when_idle", out_data, 0);
      check(!(out_valid && busy_e), "valid_during_in_busy", out_valid, 0);
      check(frame_done == done_due, "frame_done_timing", frame_done, done_due);
      done_due = 0;
      if (out_valid) begin
        check(exp_q.size() != 0, "valid_with_empty_scoreboard", out_data, 0);
        if (exp_q.size() != 0) begin
          exp_v = exp_q.pop_front();
          check(out_data == exp_v, "data_order", out_data, exp_v);
        end
        vcnt++;
        if (!first_seen) begin
          first_seen = 1;
          first_cyc  = lat;
          if (chk_lat) check(lat == PREFILL + 3, "first_valid_latency", lat, PREFILL + 3);
        end
        last_cyc = lat;
        if (vcnt == FRAME_LEN) done_due = 1;
      end
      // Results read but not yet emitted must fit in the skid plus one in-flight read.
      if (in_frame) check((rcnt - vcnt) <= SKID_DEPTH && vcnt <= FRAME_LEN, "skid_occupancy", rcnt - vcnt, SKID_DEPTH);
      if (frame_done) begin
        check(vcnt == FRAME_LEN, "valid_count", vcnt, FRAME_LEN);
        check(rcnt == FRAME_LEN, "rinc_count", rcnt, FRAME_LEN);
        if (chk_lat) check(last_cyc - first_cyc + 1 == FRAME_LEN, "contiguous_valids", last_cyc - first_cyc + 1, FRAME_LEN);
`ifdef OUT_SCHED_UNDERRUN_CNT_EN
        if (chk_under) check(underrun_cnt >= 16'd1 && underrun_cnt <= 16'd5, "underrun_cnt_range", underrun_cnt, 1);
`endif
        in_frame = 0;
      end
      if (end_check) check(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
    end
  end

  // ---------------- driver ----------------
  bit rand_mode  = 0;
  bit under_trig = 0;
  int force_empty = 0;
  int busy_left   = 0;
  bit rnd_empty   = 0;
  int seq_next    = 0;

  task automatic step();
    @(negedge clk3);
    frame_start = 1'b0;
    if (force_empty > 0) force_empty--;
    if (busy_left > 0) busy_left--;
    if (rinc_e && fifo_q.size() > 0) begin
      fifo_rdata = fifo_q.pop_front();
      if (under_trig && fifo_rdata == 16'd40) force_empty = 5;
    end
    if (rand_mode) begin
      rnd_empty = ($urandom_range(99) < 30);
      if (busy_left == 0 && $urandom_range(99) < 3) busy_left = int'($urandom_range(20, 1));
    end else begin
      rnd_empty = 0;
    end
    in_busy    = (busy_left > 0);
    fifo_empty = (fifo_q.size() == 0) || (force_empty > 0) || rnd_empty;
  endtask

  task automatic load(input int n, input bit seq, input bit expect_out);
    logic [15:0] v;
    for (int i = 0; i < n; i++) begin
      if (seq) begin
        v = 16'(seq_next);
        seq_next++;
      end else begin
        v = 16'($urandom);
      end
      fifo_q.push_back(v);
      if (expect_out) exp_q.push_back(v);
    end
  endtask

  task automatic run_frame(input int extra_fs_at);
    int cyc = 0;
    step();
    frame_start = 1'b1;
    while (!frame_done) begin
      step();
      cyc++;
      if (cyc == extra_fs_at) frame_start = 1'b1;
      if (cyc > 5000) begin
        $display("FAIL frame_timeout: no frame_done after %0d cycles, required at most 5000", cyc);
        $fatal(1, "frame timeout");
      end
    end
    step();
  endtask

  initial begin
    rst = 1'b1; frame_start = 1'b0; in_busy = 1'b0; fifo_empty = 1'b1; fifo_rdata = 16'd0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Full frame, FIFO never empty, data 0..127
    seq_next = 0;
    load(FRAME_LEN, 1, 1);
    chk_lat = 1;
    run_frame(-1);
    chk_lat = 0;

    // Underrun gap after item 40
    seq_next = 0;
    load(FRAME_LEN, 1, 1);
    under_trig = 1; chk_under = 1;
    run_frame(-1);
    under_trig = 0; chk_under = 0;

    // in_busy burst of 16 cycles during STREAM
    load(FRAME_LEN, 0, 1);
    step();
    frame_start = 1'b1;
    repeat (20) step();
    busy_left = 17;
    for (int c = 0; c < 5000 && !frame_done; c++) step();
    step();

    // Back-to-back: 200 queued, a stray frame_start mid-frame, then a second frame
    seq_next = 0;
    load(200, 1, 1);
    run_frame(50);
    load(56, 1, 1);
    run_frame(-1);

    // Reset mid-STREAM discards the frame; pending FIFO data must not appear
    load(FRAME_LEN, 0, 1);
    step();
    frame_start = 1'b1;
    repeat (30) step();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    exp_q.delete();
    fifo_q.delete();
    load(10, 0, 0);
    repeat (20) step();
    fifo_q.delete();
    step();

    // Random FIFO starvation and in_busy bursts
    rand_mode = 1;
    for (int f = 0; f < N_RAND; f++) begin
      load(FRAME_LEN, 0, 1);
      run_frame(($urandom_range(3) == 0) ? int'($urandom_range(100, 5)) : -1);
    end
    rand_mode = 0;

    end_check = 1;
    step();
    end_check = 0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
